// File: rtl/clk_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl_if
// Bundles the configuration, activity and wake-handshake signals exchanged
// between the clock-gating controller and its surroundings.
//   master : drives cfg_en_i, idle_thr_i, busy_i, req_i; observes the rest
//   slave  : the controller itself
//   cfg_en_i   - auto-gating enable
//   idle_thr_i - idle threshold (quasi-static)
//   busy_i     - gated-domain activity flag
//   req_i      - level wake request, held until ack_o
//   ack_o      - one-cycle request acknowledge
//   en_ip_o    - enable to the gate cell
//   mode_o     - gate-cell mode {gating active, source select}
//   state_o    - controller state for debug
// -----------------------------------------------------------------------------
interface clk_gate_ctrl_if #(
  parameter int IDLE_CNT_W = 8
);
  logic                  cfg_en_i;
  logic [IDLE_CNT_W-1:0] idle_thr_i;
  logic                  busy_i;
  logic                  req_i;
  logic                  ack_o;
  logic                  en_ip_o;
  logic [1:0]            mode_o;
  logic [1:0]            state_o;

  modport master (
    output cfg_en_i, idle_thr_i, busy_i, req_i,
    input  ack_o, en_ip_o, mode_o, state_o
  );

  modport slave (
    input  cfg_en_i, idle_thr_i, busy_i, req_i,
    output ack_o, en_ip_o, mode_o, state_o
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
// Idle-detect clock-gating controller running on the free-running clock.
// Drops the gate-cell enable after a programmable idle period, restores it
// on busy/request/config-drop, and acknowledges requesters only once the
// gated clock has been running for WAKE_DLY cycles.
//   clk   - free-running clock, posedge logic
//   rst_n - asynchronous active-low reset
//   bus   - clk_gate_ctrl_if.slave (config, busy, request/ack, gate outputs)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_DLY   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_gate_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  en_q, en_d;
  logic                  mode1_q, mode1_d;
  logic                  ack_q, ack_d;
  logic                  req_done_q, req_done_d;
  logic                  cfg_en_q;
  logic                  new_req;
  logic                  quiet;

  // A request counts only until it has been acknowledged once.
  assign new_req = bus.req_i & ~req_done_q;
  assign quiet   = cfg_en_q & ~bus.busy_i & ~new_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      en_q       <= 1'b1;
      mode1_q    <= 1'b0;
      ack_q      <= 1'b0;
      req_done_q <= 1'b0;
      cfg_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      en_q       <= en_d;
      mode1_q    <= mode1_d;
      ack_q      <= ack_d;
      req_done_q <= req_done_d;
      cfg_en_q   <= bus.cfg_en_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    en_d       = en_q;
    ack_d      = 1'b0;
    // Any edge that sees the request low re-arms the acknowledge.
    req_done_d = bus.req_i ? req_done_q : 1'b0;

    unique case (state_q)
      RUN: begin
        en_d = 1'b1;
        if (quiet) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        if (new_req) begin
          ack_d      = 1'b1;
          req_done_d = 1'b1;
        end
      end
      IDLE: begin
        en_d = 1'b1;
        // Loss of quiet beats the threshold compare.
        if (!quiet) begin
          state_d = RUN;
        end else if (cnt_q == bus.idle_thr_i) begin
          state_d = GATED;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + IDLE_CNT_W'(1);
        end
      end
      GATED: begin
        en_d = 1'b0;
        if (bus.busy_i || new_req || !cfg_en_q) begin
          state_d = WAKE;
          en_d    = 1'b1;
          wcnt_d  = 4'(WAKE_DLY - 1);
        end
      end
      WAKE: begin
        en_d = 1'b1;
        // Inputs are ignored here so the settle period always completes.
        if (wcnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        en_d    = 1'b1;
      end
    endcase

    // Gating stays armed outside RUN so a config drop must pass through WAKE
    // (enable restored) before the cell is told to force its clock on.
    mode1_d = (state_d == RUN) ? cfg_en_q : 1'b1;
  end

  assign bus.en_ip_o = en_q;
  assign bus.mode_o  = {mode1_q, 1'b0};
  assign bus.ack_o   = ack_q;
  assign bus.state_o = state_q;

endmodule
